m68k_prefetch_queue: RTL and testbench

- Parametrised instruction prefetch queue that sits between the bus interface and the decode stage.
- Replaces the fixed two-register fetch/decode data pipeline. Queue depth and address width are configurable.
- Keeps at most one word fetch outstanding. Handles redirects from branches and flushes.
- Presents the opcode word and a sign/zero-extended byte, word or long immediate to decode, with a valid flag.

---
 rtl/m68k_pkg.sv | 30 +++
 rtl/m68k_prefetch_queue_if.sv | 23 ++
 rtl/m68k_imm_extract.sv | 22 ++
 rtl/m68k_prefetch_queue.sv | 152 +++++++++++++++
 tb/tb_m68k_prefetch_queue.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m68k_pkg.sv
// Shared 68k front-end types: immediate size encoding, fetch step and fetch FSM states.
package m68k_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_WORD = 2'b01,
    SIZE_LONG = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  localparam int unsigned FETCH_STEP = 2;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDiscard
  } fetch_state_e;

  // Opcode word plus extension words required before the immediate is usable.
  function automatic logic [1:0] words_needed(size_e size);
    unique case (size)
      SIZE_BYTE: words_needed = 2'd2;
      SIZE_WORD: words_needed = 2'd2;
      SIZE_LONG: words_needed = 2'd3;
      SIZE_RSVD: words_needed = 2'd1;
      default:   words_needed = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/m68k_prefetch_queue_if.sv
// Word-fetch handshake between the prefetch queue (master) and the bus unit (slave).
interface m68k_prefetch_queue_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [15:0]       fetch_data;

  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_ack,
    input  fetch_data
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_ack,
    output fetch_data
  );
endinterface

// File: rtl/m68k_imm_extract.sv
// Combinational immediate/displacement extraction: sign-extends byte or word, or joins a long.
module m68k_imm_extract
  import m68k_pkg::*;
(
  input  size_e       size,
  input  logic [15:0] word1,
  input  logic [15:0] word2,
  output logic [31:0] value
);

  always_comb begin
    value = '0;
    unique case (size)
      SIZE_BYTE: value = {{24{word1[7]}}, word1[7:0]};
      SIZE_WORD: value = {{16{word1[15]}}, word1};
      SIZE_LONG: value = {word1, word2};
      SIZE_RSVD: value = '0;
      default:   value = '0;
    endcase
  end

endmodule

// File: rtl/m68k_prefetch_queue.sv
// Instruction prefetch queue with one outstanding word fetch and redirect/flush handling.
// Optional same-cycle bypass of an acked word into an empty queue: M68K_PREFETCH_BYPASS_EN.
module m68k_prefetch_queue
  import m68k_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [ADDR_W-1:0]     redirect_addr,
  m68k_prefetch_queue_if.master bus,
  input  size_e                 ext_size,
  output logic [15:0]           head_word,
  output logic [ADDR_W-1:0]     head_pc,
  output logic [31:0]           imm_value,
  output logic                  imm_valid,
  output logic [CNT_W-1:0]      count,
  input  logic                  consume,
  input  logic [1:0]            consume_n,
  output logic                  underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;

  logic [15:0]       mem_q [DEPTH];
  ptr_t              rd_ptr_q, rd_ptr_d;
  ptr_t              wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  fetch_state_e      state_q, state_d;

  logic              accept;
  logic              bypass;
  logic              bypass_pop;
  logic              wr_en;
  logic [1:0]        pop_n;
  logic [CNT_W-1:0]  cnt_eff;
  logic [15:0]       word0, word1, word2;
  logic [31:0]       ext_value;
  logic [ADDR_W-1:0] redirect_aligned;

  assign redirect_aligned = {redirect_addr[ADDR_W-1:1], 1'b0};
  // An ack only counts for a live request; acks during DISCARD or a redirect are dropped.
  assign accept = (state_q == StReq) && bus.fetch_ack && !redirect;

`ifdef M68K_PREFETCH_BYPASS_EN
  assign bypass = accept && (cnt_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign cnt_eff    = cnt_q + CNT_W'(bypass);
  assign underflow  = consume && !redirect && !rst && (CNT_W'(consume_n) > cnt_eff);
  assign pop_n      = (consume && !redirect && !underflow) ? consume_n : 2'd0;
  assign bypass_pop = bypass && (pop_n != 2'd0);
  assign wr_en      = accept && !bypass_pop;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    fetch_addr_d = fetch_addr_q;
    head_pc_d    = head_pc_q;
    state_d      = state_q;

    if (redirect) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      cnt_d        = '0;
      fetch_addr_d = redirect_aligned;
      head_pc_d    = redirect_aligned;
      // A request still in flight must have its data swallowed before refetching.
      state_d      = ((state_q != StIdle) && !bus.fetch_ack) ? StDiscard : StIdle;
    end else begin
      // A bypassed word that is popped at once never occupies a slot.
      if (!bypass_pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(pop_n);
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      cnt_d     = cnt_q + CNT_W'(accept) - CNT_W'(pop_n);
      head_pc_d = head_pc_q + (ADDR_W'(pop_n) << 1);
      if (accept) begin
        fetch_addr_d = fetch_addr_q + ADDR_W'(FETCH_STEP);
      end

      unique case (state_q)
        StIdle: begin
          if (cnt_d < CNT_W'(DEPTH)) state_d = StReq;
        end
        StReq: begin
          if (bus.fetch_ack) state_d = (cnt_d < CNT_W'(DEPTH)) ? StReq : StIdle;
        end
        StDiscard: begin
          if (bus.fetch_ack) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      fetch_addr_q <= '0;
      head_pc_q    <= '0;
      state_q      <= StIdle;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
      state_q      <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[wr_ptr_q] <= bus.fetch_data;
    end
  end

  assign bus.fetch_req  = (state_q == StReq);
  assign bus.fetch_addr = fetch_addr_q;

  assign word0 = bypass ? bus.fetch_data : mem_q[rd_ptr_q];
  assign word1 = mem_q[rd_ptr_q + ptr_t'(1)];
  assign word2 = mem_q[rd_ptr_q + ptr_t'(2)];

  m68k_imm_extract u_imm_extract (
    .size  (ext_size),
    .word1 (word1),
    .word2 (word2),
    .value (ext_value)
  );

  assign count     = cnt_eff;
  assign head_word = (cnt_eff != '0) ? word0 : 16'h0000;
  assign head_pc   = head_pc_q;
  assign imm_valid = (cnt_eff >= CNT_W'(words_needed(ext_size)));
  assign imm_value = imm_valid ? ext_value : 32'h0;

endmodule

// File: tb/tb_m68k_prefetch_queue.sv
// Self-checking bench for m68k_prefetch_queue: directed sequences, an immediate-extraction table
// and a randomised push/pop stream checked against a scoreboard of fetched words.
module tb_m68k_prefetch_queue;
  import m68k_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  size_e             ext_size;
  logic [15:0]       head_word;
  logic [ADDR_W-1:0] head_pc;
  logic [31:0]       imm_value;
  logic              imm_valid;
  logic [CNT_W-1:0]  count;
  logic              consume;
  logic [1:0]        consume_n;
  logic              underflow;

  m68k_prefetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

  m68k_prefetch_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .bus           (bus.master),
    .ext_size      (ext_size),
    .head_word     (head_word),
    .head_pc       (head_pc),
    .imm_value     (imm_value),
    .imm_valid     (imm_valid),
    .count         (count),
    .consume       (consume),
    .consume_n     (consume_n),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } sb_t;

  typedef struct {
    size_e       sz;
    logic [15:0] w [3];
    int          n;
    logic [31:0] val;
    logic        vld;
  } vec_t;

  sb_t               sb_q[$];
  vec_t              vecs[8];
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [ADDR_W-1:0] exp_addr;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Entered and left at a negedge; waits for a request, checks its address and acks it.
  task automatic ack_word(input logic [15:0] data);
    int waited = 0;
    while (!bus.fetch_req && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.fetch_req) begin
      check("fetch_req timeout", 32'(bus.fetch_req), 32'd1);
      return;
    end
    check("fetch_addr", 32'(bus.fetch_addr), 32'(exp_addr));
    bus.fetch_ack  = 1'b1;
    bus.fetch_data = data;
    sb_q.push_back('{addr: exp_addr, data: data});
    exp_addr = exp_addr + ADDR_W'(2);
    @(negedge clk);
    bus.fetch_ack = 1'b0;
  endtask

  task automatic do_redirect(input logic [ADDR_W-1:0] a);
    logic outst;
    outst         = bus.fetch_req;
    redirect      = 1'b1;
    redirect_addr = a;
    @(negedge clk);
    redirect = 1'b0;
    sb_q.delete();
    exp_addr = {a[ADDR_W-1:1], 1'b0};
    check("redirect count", 32'(count), 32'd0);
    check("redirect head_pc", 32'(head_pc), 32'(exp_addr));
    if (outst) begin
      check("discard no req", 32'(bus.fetch_req), 32'd0);
      bus.fetch_ack  = 1'b1;
      bus.fetch_data = 16'hDEAD;
      @(negedge clk);
      bus.fetch_ack = 1'b0;
      check("discard dropped", 32'(count), 32'd0);
    end
  endtask

  task automatic do_consume(input int n);
    logic [1:0] nn;
    nn = n[1:0];
    if (sb_q.size() > 0) begin
      check("pop head_word", 32'(head_word), 32'(sb_q[0].data));
      check("pop head_pc", 32'(head_pc), 32'(sb_q[0].addr));
    end
    consume   = 1'b1;
    consume_n = nn;
    @(negedge clk);
    consume = 1'b0;
    repeat (n) if (sb_q.size() > 0) void'(sb_q.pop_front());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{sz: SIZE_LONG, w: '{16'h0600, 16'h8001, 16'h0002}, n: 3, val: 32'h80010002, vld: 1'b1};
    vecs[1] = '{sz: SIZE_BYTE, w: '{16'h0600, 16'h00F0, 16'h0000}, n: 2, val: 32'hFFFFFFF0, vld: 1'b1};
    vecs[2] = '{sz: SIZE_BYTE, w: '{16'h0600, 16'h0000, 16'h0000}, n: 1, val: 32'h00000000, vld: 1'b0};
    vecs[3] = '{sz: SIZE_WORD, w: '{16'h3000, 16'h8000, 16'h0000}, n: 2, val: 32'hFFFF8000, vld: 1'b1};
    vecs[4] = '{sz: SIZE_WORD, w: '{16'h3000, 16'h7FFF, 16'h0000}, n: 2, val: 32'h00007FFF, vld: 1'b1};
    vecs[5] = '{sz: SIZE_LONG, w: '{16'h2000, 16'h1234, 16'h0000}, n: 2, val: 32'h00000000, vld: 1'b0};
    vecs[6] = '{sz: SIZE_RSVD, w: '{16'h4AFC, 16'h0000, 16'h0000}, n: 1, val: 32'h00000000, vld: 1'b1};
    vecs[7] = '{sz: SIZE_BYTE, w: '{16'h7000, 16'hFF7F, 16'h0000}, n: 2, val: 32'h0000007F, vld: 1'b1};

    rst            = 1'b1;
    redirect       = 1'b0;
    redirect_addr  = '0;
    ext_size       = SIZE_BYTE;
    consume        = 1'b0;
    consume_n      = 2'd0;
    bus.fetch_ack  = 1'b0;
    bus.fetch_data = 16'h0000;
    exp_addr       = '0;

    repeat (2) @(negedge clk);
    check("reset count", 32'(count), 32'd0);
    check("reset fetch_req", 32'(bus.fetch_req), 32'd0);
    check("reset fetch_addr", 32'(bus.fetch_addr), 32'd0);
    check("reset head_pc", 32'(head_pc), 32'd0);
    check("reset head_word", 32'(head_word), 32'd0);
    check("reset imm_value", imm_value, 32'd0);
    check("reset imm_valid", 32'(imm_valid), 32'd0);
    check("reset underflow", 32'(underflow), 32'd0);
    rst = 1'b0;

    ack_word(16'h4E71);
    ack_word(16'h1234);
    ack_word(16'h5678);
    check("fill fetch_addr", 32'(bus.fetch_addr), 32'h6);
    check("fill count", 32'(count), 32'd3);
    check("fill head_word", 32'(head_word), 32'h4E71);
    check("fill head_pc", 32'(head_pc), 32'h0);

    ack_word(16'h9ABC);
    check("full count", 32'(count), 32'd4);
    check("full no req", 32'(bus.fetch_req), 32'd0);
    @(negedge clk);
    check("full no req hold", 32'(bus.fetch_req), 32'd0);
    do_consume(1);
    check("req after pop", 32'(bus.fetch_req), 32'd1);
    check("count after pop", 32'(count), 32'd3);
    do_consume(2);
    check("head after pop2", 32'(head_word), 32'h9ABC);
    check("pc after pop2", 32'(head_pc), 32'h6);

    for (int i = 0; i < 8; i++) begin
      do_redirect(ADDR_W'(32'h2000 + i * 16));
      ext_size = vecs[i].sz;
      for (int j = 0; j < vecs[i].n; j++) ack_word(vecs[i].w[j]);
      #1;
      check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].n));
      check($sformatf("vec%0d imm_value", i), imm_value, vecs[i].val);
      check($sformatf("vec%0d imm_valid", i), 32'(imm_valid), 32'(vecs[i].vld));
    end

    check("pre-redirect req", 32'(bus.fetch_req), 32'd1);
    do_redirect(24'h1000);
    ack_word(16'hCAFE);
    check("post-redirect head_word", 32'(head_word), 32'hCAFE);
    check("post-redirect head_pc", 32'(head_pc), 32'h1000);
    check("post-redirect count", 32'(count), 32'd1);

    consume   = 1'b1;
    consume_n = 2'd2;
    #1;
    check("underflow pulse", 32'(underflow), 32'd1);
    @(negedge clk);
    consume = 1'b0;
    #1;
    check("underflow cleared", 32'(underflow), 32'd0);
    check("underflow count kept", 32'(count), 32'd1);
    check("underflow head kept", 32'(head_word), 32'hCAFE);

    do_redirect(24'hFFFFFE);
    ack_word(16'h1111);
    check("wrap fetch_addr", 32'(bus.fetch_addr), 32'h0);
    check("wrap head_pc", 32'(head_pc), 32'hFFFFFE);

    // Stream with concurrent pushes and pops checked against the scoreboard.
    for (int c = 0; c < 80; c++) begin
      logic do_ack, do_pop;
      int   n;
      check("stream count", 32'(count), 32'(sb_q.size()));
      do_ack = bus.fetch_req && ($urandom_range(0, 1) == 1);
      do_pop = (sb_q.size() > 0) && ($urandom_range(0, 2) == 0);
      n = 0;
      if (do_pop) begin
        n = $urandom_range(1, (sb_q.size() < 3) ? sb_q.size() : 3);
        check("stream head_word", 32'(head_word), 32'(sb_q[0].data));
        check("stream head_pc", 32'(head_pc), 32'(sb_q[0].addr));
        consume   = 1'b1;
        consume_n = 2'(n);
      end
      if (do_ack) begin
        logic [15:0] d;
        d = 16'($urandom);
        check("stream fetch_addr", 32'(bus.fetch_addr), 32'(exp_addr));
        bus.fetch_ack  = 1'b1;
        bus.fetch_data = d;
        repeat (n) void'(sb_q.pop_front());
        sb_q.push_back('{addr: exp_addr, data: d});
        exp_addr = exp_addr + ADDR_W'(2);
      end else begin
        repeat (n) void'(sb_q.pop_front());
      end
      @(negedge clk);
      consume       = 1'b0;
      bus.fetch_ack = 1'b0;
    end

    // Redirect with an ack in the same cycle: the word is dropped and no discard is needed.
    while (!bus.fetch_req) @(negedge clk);
    redirect       = 1'b1;
    redirect_addr  = 24'h3001;
    bus.fetch_ack  = 1'b1;
    bus.fetch_data = 16'hBEEF;
    @(negedge clk);
    redirect      = 1'b0;
    bus.fetch_ack = 1'b0;
    sb_q.delete();
    exp_addr = 24'h3000;
    check("redirect+ack count", 32'(count), 32'd0);
    check("redirect+ack head_pc", 32'(head_pc), 32'h3000);
    ack_word(16'h2222);
    check("redirect+ack head_word", 32'(head_word), 32'h2222);

    while (!bus.fetch_req) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst count", 32'(count), 32'd0);
    check("mid rst fetch_req", 32'(bus.fetch_req), 32'd0);
    check("mid rst fetch_addr", 32'(bus.fetch_addr), 32'd0);
    check("mid rst head_pc", 32'(head_pc), 32'd0);
    check("mid rst head_word", 32'(head_word), 32'd0);
    check("mid rst imm_value", imm_value, 32'd0);
    check("mid rst imm_valid", 32'(imm_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
